// File: rtl/riscv_dmem_responder_pkg.sv
// Shared widths, funct3 encodings and types for the data-memory responder.
// Macros are guarded so any file of the slice may pull them in again.
`ifndef RISCV_DMEM_DEFS
`define RISCV_DMEM_DEFS
`define XLEN      32
`define FUNCT3_B  3'd0
`define FUNCT3_H  3'd1
`define FUNCT3_W  3'd2
`define FUNCT3_BU 3'd4
`define FUNCT3_HU 3'd5
`endif

package riscv_dmem_responder_pkg;

    localparam int XLEN = `XLEN;

    localparam logic [2:0] F3_B  = `FUNCT3_B;
    localparam logic [2:0] F3_H  = `FUNCT3_H;
    localparam logic [2:0] F3_W  = `FUNCT3_W;
    localparam logic [2:0] F3_BU = `FUNCT3_BU;
    localparam logic [2:0] F3_HU = `FUNCT3_HU;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    typedef struct packed {
        logic            we;
        logic [2:0]      funct3;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wr_data;
    } dmem_req_t;

endpackage

// File: rtl/riscv_dmem_responder_if.sv
// Request/response bus between the datapath and the data-memory responder.
// The datapath drives the master side, the responder the slave side.
interface riscv_dmem_responder_if
    import riscv_dmem_responder_pkg::*;
#(
    parameter int XLEN_W = XLEN
);
    logic              i_dmem_req;
    logic              i_dmem_we;
    logic [2:0]        i_dmem_funct3;
    logic [XLEN_W-1:0] i_dmem_addr;
    logic [XLEN_W-1:0] i_dmem_wr_data;
    logic              o_dmem_ready;
    logic              o_dmem_ack;
    logic              o_dmem_err;
    logic [XLEN_W-1:0] o_dmem_rd_data;

    modport master (
        output i_dmem_req,
        output i_dmem_we,
        output i_dmem_funct3,
        output i_dmem_addr,
        output i_dmem_wr_data,
        input  o_dmem_ready,
        input  o_dmem_ack,
        input  o_dmem_err,
        input  o_dmem_rd_data
    );

    modport slave (
        input  i_dmem_req,
        input  i_dmem_we,
        input  i_dmem_funct3,
        input  i_dmem_addr,
        input  i_dmem_wr_data,
        output o_dmem_ready,
        output o_dmem_ack,
        output o_dmem_err,
        output o_dmem_rd_data
    );
endinterface

// File: rtl/riscv_dmem_align.sv
// Alignment logic: fault detection, store lane steering, load extraction.
// Purely combinational; the responder top owns state and storage.
module riscv_dmem_align
    import riscv_dmem_responder_pkg::*;
#(
    parameter int XLEN_W = XLEN,
    parameter int AW     = 10
) (
    input  logic              we,
    input  logic [2:0]        funct3,
    input  logic [XLEN_W-1:0] addr,
    input  logic [XLEN_W-1:0] wr_data,
    input  logic [XLEN_W-1:0] rd_word,
    output logic              err,
    output logic [3:0]        be,
    output logic [XLEN_W-1:0] st_data,
    output logic [XLEN_W-1:0] ld_data
);
    logic       is_b;
    logic       is_h;
    logic       is_w;
    logic       ill;
    logic       mis;
    logic       oor;
    logic [7:0]  sel_b;
    logic [15:0] sel_h;

    assign is_b = (funct3[1:0] == 2'd0);
    assign is_h = (funct3[1:0] == 2'd1);
    assign is_w = (funct3 == F3_W);

    // funct3[1:0]==3 covers encodings 3 and 7; 6 is the only other hole
    assign ill = (funct3[1:0] == 2'd3)
               || (funct3 == 3'd6)
               || (we && funct3[2]);

    assign oor = |addr[XLEN_W-1:AW+2];

    always_comb begin
        mis = 1'b0;
        unique case (1'b1)
            is_h:    mis = addr[0];
            is_w:    mis = |addr[1:0];
            default: mis = 1'b0;
        endcase
    end

    assign err = ill || mis || oor;

    always_comb begin
        be      = 4'b0000;
        st_data = '0;
        unique case (1'b1)
            is_b: begin
                be      = 4'b0001 << addr[1:0];
                st_data = {4{wr_data[7:0]}};
            end
            is_h: begin
                be      = addr[1] ? 4'b1100 : 4'b0011;
                st_data = {2{wr_data[15:0]}};
            end
            is_w: begin
                be      = 4'b1111;
                st_data = wr_data;
            end
            default: ;
        endcase
    end

    assign sel_b = rd_word[{addr[1:0], 3'b000} +: 8];
    assign sel_h = addr[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        ld_data = '0;
        unique case (funct3)
            F3_B:    ld_data = {{(XLEN_W-8){sel_b[7]}}, sel_b};
            F3_BU:   ld_data = {{(XLEN_W-8){1'b0}}, sel_b};
            F3_H:    ld_data = {{(XLEN_W-16){sel_h[15]}}, sel_h};
            F3_HU:   ld_data = {{(XLEN_W-16){1'b0}}, sel_h};
            F3_W:    ld_data = rd_word;
            default: ld_data = '0;
        endcase
    end
endmodule

// File: rtl/riscv_dmem_responder.sv
// Data-memory responder: one access at a time, optional wait states,
// byte/halfword/word access into a word array with a one-cycle ack.
module riscv_dmem_responder
    import riscv_dmem_responder_pkg::*;
#(
    parameter int              XLEN_W      = `XLEN,
    parameter int              DEPTH       = 1024,
    parameter int              WAIT_CYCLES = 0,
    parameter logic [XLEN-1:0] MEM_INIT    = '0
) (
    input  logic                   i_clk,
    input  logic                   i_rstn,
    riscv_dmem_responder_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);

    state_t            state_q;
    state_t            state_d;
    logic [3:0]        cnt_q;
    dmem_req_t         req_q;
    dmem_req_t         live;
    dmem_req_t         cur;
    logic              accept;
    logic              commit;
    logic              err_q;
    logic [XLEN_W-1:0] rd_q;

    logic              a_err;
    logic [3:0]        a_be;
    logic [XLEN_W-1:0] a_st;
    logic [XLEN_W-1:0] a_ld;
    logic [XLEN_W-1:0] rd_word;
    logic [AW-1:0]     idx;

    logic [XLEN_W-1:0] mem [DEPTH] = '{default: MEM_INIT};

    assign live = '{
        we:      bus.i_dmem_we,
        funct3:  bus.i_dmem_funct3,
        addr:    bus.i_dmem_addr,
        wr_data: bus.i_dmem_wr_data
    };

    assign accept = bus.i_dmem_req && (state_q == ST_IDLE);

    // With no wait states the access commits on the accept edge itself,
    // so the live bus must feed the datapath while in IDLE.
    assign cur     = (state_q == ST_IDLE) ? live : req_q;
    assign idx     = cur.addr[AW+1:2];
    assign rd_word = mem[idx];
    assign commit  = (state_d == ST_RESP) && (state_q != ST_RESP);

    riscv_dmem_align #(
        .XLEN_W (XLEN_W),
        .AW     (AW)
    ) u_align (
        .we      (cur.we),
        .funct3  (cur.funct3),
        .addr    (cur.addr),
        .wr_data (cur.wr_data),
        .rd_word (rd_word),
        .err     (a_err),
        .be      (a_be),
        .st_data (a_st),
        .ld_data (a_ld)
    );

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            req_q   <= '0;
            err_q   <= 1'b0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                req_q <= live;
                cnt_q <= (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
            end else if (state_q == ST_WAIT && cnt_q != 4'd0) begin
                cnt_q <= cnt_q - 4'd1;
            end
            if (commit) begin
                err_q <= a_err;
                rd_q  <= (a_err || cur.we) ? '0 : a_ld;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.i_dmem_req)
                    state_d = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0)
                    state_d = ST_RESP;
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.o_dmem_ready   = (state_q == ST_IDLE);
        bus.o_dmem_ack     = (state_q == ST_RESP);
        bus.o_dmem_err     = err_q;
        bus.o_dmem_rd_data = rd_q;
    end

    // Storage is not reset; reset only blocks a write racing its release.
    always_ff @(posedge i_clk) begin
        if (commit && cur.we && !a_err && i_rstn) begin
            for (int b = 0; b < 4; b++) begin
                if (a_be[b])
                    mem[idx][8*b +: 8] <= a_st[8*b +: 8];
            end
        end
    end
endmodule

// File: tb/tb_riscv_dmem_responder.sv
// Scoreboard bench: two responders (0 and 3 wait states) against a
// byte-addressed reference memory kept in the bench.
module tb_riscv_dmem_responder;
    import riscv_dmem_responder_pkg::*;

    localparam int          DEPTH = 1024;
    localparam logic [31:0] MINIT = 32'h1357_9BDF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sel = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [2:0]  f3 = 3'd0;
    logic [31:0] addr = '0;
    logic [31:0] wd = '0;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    riscv_dmem_responder_if #(.XLEN_W(32)) bus0 ();
    riscv_dmem_responder_if #(.XLEN_W(32)) bus3 ();

    assign bus0.i_dmem_req     = req & ~sel;
    assign bus3.i_dmem_req     = req & sel;
    assign bus0.i_dmem_we      = we;
    assign bus3.i_dmem_we      = we;
    assign bus0.i_dmem_funct3  = f3;
    assign bus3.i_dmem_funct3  = f3;
    assign bus0.i_dmem_addr    = addr;
    assign bus3.i_dmem_addr    = addr;
    assign bus0.i_dmem_wr_data = wd;
    assign bus3.i_dmem_wr_data = wd;

    riscv_dmem_responder #(
        .XLEN_W(32), .DEPTH(DEPTH), .WAIT_CYCLES(0), .MEM_INIT(MINIT)
    ) dut0 (
        .i_clk(clk), .i_rstn(rst_n), .bus(bus0)
    );

    riscv_dmem_responder #(
        .XLEN_W(32), .DEPTH(DEPTH), .WAIT_CYCLES(3), .MEM_INIT(MINIT)
    ) dut3 (
        .i_clk(clk), .i_rstn(rst_n), .bus(bus3)
    );

    logic        rdy, ack, er, oth_ack;
    logic [31:0] rd;
    assign rdy     = sel ? bus3.o_dmem_ready   : bus0.o_dmem_ready;
    assign ack     = sel ? bus3.o_dmem_ack     : bus0.o_dmem_ack;
    assign er      = sel ? bus3.o_dmem_err     : bus0.o_dmem_err;
    assign rd      = sel ? bus3.o_dmem_rd_data : bus0.o_dmem_rd_data;
    assign oth_ack = sel ? bus0.o_dmem_ack     : bus3.o_dmem_ack;

    typedef struct {
        logic        err;
        logic [31:0] data;
        int          due;
    } exp_t;
    exp_t q[$];

    logic [7:0] mb0 [int];
    logic [7:0] mb3 [int];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] rdb(input bit s, input int a);
        logic [31:0] w;
        w = MINIT;
        if (s && mb3.exists(a)) return mb3[a];
        if (!s && mb0.exists(a)) return mb0[a];
        return w[8*(a%4) +: 8];
    endfunction

    task automatic model(input bit s, input logic w, input logic [2:0] f,
                         input logic [31:0] a, input logic [31:0] d,
                         output logic e, output logic [31:0] r);
        int n;
        logic [31:0] v;
        n = (f[1:0] == 2'd0) ? 1 : (f[1:0] == 2'd1) ? 2 : 4;
        e = (f == 3'd3) || (f == 3'd6) || (f == 3'd7) || (w && f[2])
            || (a % n != 0) || (a >= 4 * DEPTH);
        r = '0;
        if (!e) begin
            if (w) begin
                for (int i = 0; i < n; i++) begin
                    if (s) mb3[int'(a) + i] = d[8*i +: 8];
                    else   mb0[int'(a) + i] = d[8*i +: 8];
                end
            end else begin
                v = '0;
                for (int i = 0; i < n; i++)
                    v[8*i +: 8] = rdb(s, int'(a) + i);
                if (n == 1 && !f[2]) v = {{24{v[7]}}, v[7:0]};
                if (n == 2 && !f[2]) v = {{16{v[15]}}, v[15:0]};
                r = v;
            end
        end
    endtask

    logic ack_prev = 1'b0;
    always @(negedge clk) begin
        exp_t x;
        if (rst_n) begin
            chk("idle_dut_ack", {31'd0, oth_ack}, 32'd0);
            if (ack) begin
                chk("ack_width", {31'd0, ack_prev}, 32'd0);
                if (q.size() == 0) begin
                    chk("spurious_ack", 32'd1, 32'd0);
                end else begin
                    x = q.pop_front();
                    chk("err", {31'd0, er}, {31'd0, x.err});
                    chk("rd_data", rd, x.data);
                    chk("ack_cycle", cyc, x.due);
                end
            end
        end
        ack_prev <= ack & rst_n;
    end

    // Called just after a negedge; returns at the negedge after acceptance.
    task automatic issue(input logic w, input logic [2:0] f,
                         input logic [31:0] a, input logic [31:0] d,
                         input bit track);
        int n;
        logic e;
        logic [31:0] r;
        n = 0;
        while (!rdy) begin
            @(negedge clk);
            n++;
            if (n > 50) begin
                chk("ready_timeout", 32'd0, 32'd1);
                return;
            end
        end
        req = 1'b1; we = w; f3 = f; addr = a; wd = d;
        if (track) begin
            model(sel, w, f, a, d, e, r);
            q.push_back('{err: e, data: r, due: cyc + 1 + (sel ? 3 : 0)});
        end
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (q.size() != 0 || !rdy) begin
            @(negedge clk);
            n++;
            if (n > 100) begin
                chk("drain_timeout", q.size(), 32'd0);
                q.delete();
                return;
            end
        end
    endtask

    task automatic rand_run(input int cnt);
        logic [31:0] a;
        logic [2:0]  f;
        for (int i = 0; i < cnt; i++) begin
            f = 3'($urandom_range(0, 7));
            a = 32'($urandom_range(0, 63));
            if ($urandom_range(0, 1) == 0) a = a & ~32'h3;
            if ($urandom_range(0, 9) == 0) a = 32'(4 * DEPTH) + ($urandom & 32'hFFFC);
            issue(1'($urandom_range(0, 1)), f, a, $urandom, 1'b1);
        end
        wait_idle();
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_ready0", {31'd0, bus0.o_dmem_ready}, 32'd1);
        chk("rst_ack3", {31'd0, bus3.o_dmem_ack}, 32'd0);
        chk("rst_rd3", bus3.o_dmem_rd_data, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        issue(1'b1, F3_W, 32'h10, 32'h8765_43A1, 1'b1);
        issue(1'b0, F3_W, 32'h10, 32'h0, 1'b1);
        issue(1'b0, F3_B, 32'h10, 32'h0, 1'b1);
        issue(1'b0, F3_BU, 32'h10, 32'h0, 1'b1);
        issue(1'b0, F3_H, 32'h12, 32'h0, 1'b1);
        issue(1'b0, F3_HU, 32'h12, 32'h0, 1'b1);
        issue(1'b1, F3_B, 32'h11, 32'hFF, 1'b1);
        issue(1'b0, F3_W, 32'h10, 32'h0, 1'b1);
        issue(1'b0, F3_W, 32'h11, 32'h0, 1'b1);
        issue(1'b1, F3_H, 32'h13, 32'h1234, 1'b1);
        issue(1'b0, F3_W, 32'h10, 32'h0, 1'b1);
        issue(1'b0, F3_W, 32'(4 * DEPTH), 32'h0, 1'b1);
        issue(1'b0, 3'd3, 32'h10, 32'h0, 1'b1);
        issue(1'b0, F3_W, 32'h10, 32'h0, 1'b1);
        wait_idle();

        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ready", {31'd0, rdy}, 32'd1);
        chk("arst_ack", {31'd0, ack}, 32'd0);
        chk("arst_err", {31'd0, er}, 32'd0);
        chk("arst_rd", rd, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(1'b0, F3_W, 32'h10, 32'h0, 1'b1);
        rand_run(80);

        sel = 1'b1;
        @(negedge clk);
        issue(1'b0, F3_W, 32'h10, 32'h0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            chk("wait_ready_low", {31'd0, rdy}, 32'd0);
            req = (i == 1);
            @(negedge clk);
        end
        req = 1'b0;
        chk("ready_back", {31'd0, rdy}, 32'd1);
        repeat (4) @(negedge clk);

        issue(1'b1, F3_W, 32'h40, 32'h1111_2222, 1'b1);
        wait_idle();
        issue(1'b1, F3_W, 32'h40, 32'hDEAD_BEEF, 1'b0);
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        issue(1'b0, F3_W, 32'h40, 32'h0, 1'b1);
        wait_idle();
        rand_run(80);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
